// File: rtl/alu_exec_unit.sv
// Integer/branch execute stage: computes RS-issued ops, queues results, and presents the queue head on the CDB.
// Optional ALU_FLUSH_EN adds the ROB_clear input, which empties the result queue.
module alu_exec_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ROBID_W    = 4,
    parameter int unsigned OPID_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
`ifdef ALU_FLUSH_EN
    input  logic               ROB_clear,
`endif
    input  logic               RS_input_valid,
    input  logic [OPID_W-1:0]  RS_OP_ID,
    input  logic [DATA_W-1:0]  RS_inst_pc,
    input  logic [DATA_W-1:0]  RS_reg_rs1,
    input  logic [DATA_W-1:0]  RS_reg_rs2,
    input  logic [DATA_W-1:0]  RS_imm,
    input  logic [ROBID_W-1:0] RS_ROB_id,
    output logic               ALU_almost_full,
    output logic               ALU_overflow,
    output logic               CDB_valid,
    input  logic               CDB_grant,
    output logic [ROBID_W-1:0] CDB_ROB_id,
    output logic [DATA_W-1:0]  CDB_value,
    output logic               CDB_jump,
    output logic [DATA_W-1:0]  CDB_target_pc
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    // Decoder OpIdBus encoding (loads/stores are not executed here and fall to default)
    localparam logic [OPID_W-1:0] OP_LUI   = OPID_W'(1);
    localparam logic [OPID_W-1:0] OP_AUIPC = OPID_W'(2);
    localparam logic [OPID_W-1:0] OP_JAL   = OPID_W'(3);
    localparam logic [OPID_W-1:0] OP_JALR  = OPID_W'(4);
    localparam logic [OPID_W-1:0] OP_BEQ   = OPID_W'(5);
    localparam logic [OPID_W-1:0] OP_BNE   = OPID_W'(6);
    localparam logic [OPID_W-1:0] OP_BLT   = OPID_W'(7);
    localparam logic [OPID_W-1:0] OP_BGE   = OPID_W'(8);
    localparam logic [OPID_W-1:0] OP_BLTU  = OPID_W'(9);
    localparam logic [OPID_W-1:0] OP_BGEU  = OPID_W'(10);
    localparam logic [OPID_W-1:0] OP_ADDI  = OPID_W'(19);
    localparam logic [OPID_W-1:0] OP_SLTI  = OPID_W'(20);
    localparam logic [OPID_W-1:0] OP_SLTIU = OPID_W'(21);
    localparam logic [OPID_W-1:0] OP_XORI  = OPID_W'(22);
    localparam logic [OPID_W-1:0] OP_ORI   = OPID_W'(23);
    localparam logic [OPID_W-1:0] OP_ANDI  = OPID_W'(24);
    localparam logic [OPID_W-1:0] OP_SLLI  = OPID_W'(25);
    localparam logic [OPID_W-1:0] OP_SRLI  = OPID_W'(26);
    localparam logic [OPID_W-1:0] OP_SRAI  = OPID_W'(27);
    localparam logic [OPID_W-1:0] OP_ADD   = OPID_W'(28);
    localparam logic [OPID_W-1:0] OP_SUB   = OPID_W'(29);
    localparam logic [OPID_W-1:0] OP_SLL   = OPID_W'(30);
    localparam logic [OPID_W-1:0] OP_SLT   = OPID_W'(31);
    localparam logic [OPID_W-1:0] OP_SLTU  = OPID_W'(32);
    localparam logic [OPID_W-1:0] OP_XOR   = OPID_W'(33);
    localparam logic [OPID_W-1:0] OP_SRL   = OPID_W'(34);
    localparam logic [OPID_W-1:0] OP_SRA   = OPID_W'(35);
    localparam logic [OPID_W-1:0] OP_OR    = OPID_W'(36);
    localparam logic [OPID_W-1:0] OP_AND   = OPID_W'(37);

    typedef struct packed {
        logic [ROBID_W-1:0] rob_id;
        logic [DATA_W-1:0]  value;
        logic               jump;
        logic [DATA_W-1:0]  target;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             head, head_n, res_c;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0]   count, count_n;
    logic               ovf_n, push_req_c, pop_c, do_write_c, flush_c;
    logic [SHAMT_W-1:0] shamt_i_c, shamt_r_c;
    logic [DATA_W-1:0]  rs1, rs2, imm, pc;

    assign rs1       = RS_reg_rs1;
    assign rs2       = RS_reg_rs2;
    assign imm       = RS_imm;
    assign pc        = RS_inst_pc;
    assign shamt_i_c = imm[SHAMT_W-1:0];
    assign shamt_r_c = rs2[SHAMT_W-1:0];

`ifdef ALU_FLUSH_EN
    assign flush_c = ROB_clear;
`else
    assign flush_c = 1'b0;
`endif

    // Result compute; unknown ops yield an all-zero result that still carries the ROB tag
    always_comb begin
        res_c        = '0;
        res_c.rob_id = RS_ROB_id;
        case (RS_OP_ID)
            OP_LUI:   res_c.value = imm;
            OP_AUIPC: res_c.value = pc + imm;
            OP_JAL: begin
                res_c.value  = pc + DATA_W'(4);
                res_c.jump   = 1'b1;
                res_c.target = pc + imm;
            end
            OP_JALR: begin
                res_c.value  = pc + DATA_W'(4);
                res_c.jump   = 1'b1;
                res_c.target = (rs1 + imm) & ~DATA_W'(1);
            end
            OP_BEQ:   begin res_c.jump = (rs1 == rs2);                   res_c.target = pc + imm; end
            OP_BNE:   begin res_c.jump = (rs1 != rs2);                   res_c.target = pc + imm; end
            OP_BLT:   begin res_c.jump = ($signed(rs1) <  $signed(rs2)); res_c.target = pc + imm; end
            OP_BGE:   begin res_c.jump = ($signed(rs1) >= $signed(rs2)); res_c.target = pc + imm; end
            OP_BLTU:  begin res_c.jump = (rs1 <  rs2);                   res_c.target = pc + imm; end
            OP_BGEU:  begin res_c.jump = (rs1 >= rs2);                   res_c.target = pc + imm; end
            OP_ADDI:  res_c.value = rs1 + imm;
            OP_SLTI:  res_c.value = DATA_W'($signed(rs1) < $signed(imm));
            OP_SLTIU: res_c.value = DATA_W'(rs1 < imm);
            OP_XORI:  res_c.value = rs1 ^ imm;
            OP_ORI:   res_c.value = rs1 | imm;
            OP_ANDI:  res_c.value = rs1 & imm;
            OP_SLLI:  res_c.value = rs1 << shamt_i_c;
            OP_SRLI:  res_c.value = rs1 >> shamt_i_c;
            OP_SRAI:  res_c.value = DATA_W'($signed(rs1) >>> shamt_i_c);
            OP_ADD:   res_c.value = rs1 + rs2;
            OP_SUB:   res_c.value = rs1 - rs2;
            OP_SLL:   res_c.value = rs1 << shamt_r_c;
            OP_SLT:   res_c.value = DATA_W'($signed(rs1) < $signed(rs2));
            OP_SLTU:  res_c.value = DATA_W'(rs1 < rs2);
            OP_XOR:   res_c.value = rs1 ^ rs2;
            OP_SRL:   res_c.value = rs1 >> shamt_r_c;
            OP_SRA:   res_c.value = DATA_W'($signed(rs1) >>> shamt_r_c);
            OP_OR:    res_c.value = rs1 | rs2;
            OP_AND:   res_c.value = rs1 & rs2;
            default:  ;
        endcase
    end

    assign push_req_c = rdy & RS_input_valid;
    assign pop_c      = rdy & CDB_grant & (count != '0);

    // Queue next-state; the head register is preloaded so CDB outputs come straight from flops
    always_comb begin
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        count_n    = count;
        ovf_n      = ALU_overflow;
        head_n     = head;
        do_write_c = 1'b0;
        if (rdy && flush_c) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
            head_n   = '0;
        end else if (rdy) begin
            do_write_c = push_req_c & ((count != CNT_W'(FIFO_DEPTH)) | pop_c);
            if (push_req_c && !do_write_c)
                ovf_n = 1'b1;
            if (do_write_c)
                wr_ptr_n = wr_ptr + PTR_W'(1);
            if (pop_c)
                rd_ptr_n = rd_ptr + PTR_W'(1);
            count_n = count + CNT_W'(do_write_c) - CNT_W'(pop_c);
            if (count_n == '0)
                head_n = '0;
            else if (count == '0 || (pop_c && count == CNT_W'(1)))
                head_n = res_c;
            else if (pop_c)
                head_n = mem[rd_ptr + PTR_W'(1)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            head            <= '0;
            CDB_valid       <= 1'b0;
            ALU_almost_full <= 1'b0;
            ALU_overflow    <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr_n;
            rd_ptr          <= rd_ptr_n;
            count           <= count_n;
            head            <= head_n;
            CDB_valid       <= (count_n != '0);
            ALU_almost_full <= (count_n >= CNT_W'(FIFO_DEPTH - 1));
            ALU_overflow    <= ovf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write_c)
            mem[wr_ptr] <= res_c;
    end

    assign CDB_ROB_id    = head.rob_id;
    assign CDB_value     = head.value;
    assign CDB_jump      = head.jump;
    assign CDB_target_pc = head.target;
endmodule
